noc_axis_inject_arbiter: RTL and testbench

- Multi-channel injection front-end for a router local port: merges NUM_CHANNELS AXI-Stream sources into one credit-flow-controlled flit stream (data/dest/is_tail/send out, credit in).
- Packet-granular round-robin arbitration, so packets from different channels never interleave.
- The channel index is encoded into the TID field of the flit destination.
- Sits between user endpoints and router port 0 in the clk_noc domain; generalises the single-source injection path to N sources.

---
 rtl/noc_axis_inject_arbiter_if.sv | 39 +++
 rtl/noc_axis_inject_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_noc_axis_inject_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_axis_inject_arbiter_if.sv
// ---------------------------------------------------------------------------
// noc_axis_inject_arbiter_if
// Bundles the signals between the user endpoints and the injection arbiter,
// and between the arbiter and router local port 0.
//   axis_in_tvalid/tready/tdata/tlast/tdest : per-channel AXI-Stream sources
//   data_out/dest_out/is_tail_out/send_out  : flit stream towards the router
//   credit_in                               : one-cycle credit return pulse
// Modports:
//   master : endpoint/router side (drives AXIS inputs and credit_in)
//   slave  : arbiter side (drives tready and the flit outputs)
// ---------------------------------------------------------------------------
interface noc_axis_inject_arbiter_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int TDATA_WIDTH  = 64,
    parameter int TDEST_WIDTH  = 4,
    parameter int TID_WIDTH    = 2,
    parameter int DEST_WIDTH   = TDEST_WIDTH + TID_WIDTH
);
    logic [0:NUM_CHANNELS-1]                  axis_in_tvalid;
    logic [0:NUM_CHANNELS-1]                  axis_in_tready;
    logic [0:NUM_CHANNELS-1][TDATA_WIDTH-1:0] axis_in_tdata;
    logic [0:NUM_CHANNELS-1]                  axis_in_tlast;
    logic [0:NUM_CHANNELS-1][TDEST_WIDTH-1:0] axis_in_tdest;
    logic [TDATA_WIDTH-1:0]                   data_out;
    logic [DEST_WIDTH-1:0]                    dest_out;
    logic                                     is_tail_out;
    logic                                     send_out;
    logic                                     credit_in;

    modport master (
        output axis_in_tvalid, axis_in_tdata, axis_in_tlast, axis_in_tdest, credit_in,
        input  axis_in_tready, data_out, dest_out, is_tail_out, send_out
    );

    modport slave (
        input  axis_in_tvalid, axis_in_tdata, axis_in_tlast, axis_in_tdest, credit_in,
        output axis_in_tready, data_out, dest_out, is_tail_out, send_out
    );
endinterface

// File: rtl/noc_axis_inject_arbiter.sv
// ---------------------------------------------------------------------------
// noc_axis_inject_arbiter
// Merges NUM_CHANNELS AXI-Stream sources into one credit-flow-controlled flit
// stream for router local port 0. Arbitration is packet-granular round robin,
// so flits of different packets never interleave. The winning channel index
// is placed in the TID field of the flit destination.
//
// Ports:
//   clk_noc        : NoC clock, single clock domain
//   rst_noc        : asynchronous active-high reset
//   bus (slave)    : AXIS inputs, flit outputs and credit_in
//   stat_clear     : (NOC_INJECT_STATS_EN only) synchronous counter clear
//   stat_pkt_count : (NOC_INJECT_STATS_EN only) per-channel packet counts
//
// Optional feature macro: NOC_INJECT_STATS_EN adds saturating per-channel
// packet counters.
// ---------------------------------------------------------------------------
module noc_axis_inject_arbiter #(
    parameter int NUM_CHANNELS      = 4,
    parameter int TDATA_WIDTH       = 64,
    parameter int TDEST_WIDTH       = 4,
    parameter int TID_WIDTH         = 2,
    parameter int FLIT_BUFFER_DEPTH = 4,
    parameter int DEST_WIDTH        = TDEST_WIDTH + TID_WIDTH
) (
    input  logic                        clk_noc,
    input  logic                        rst_noc,
`ifdef NOC_INJECT_STATS_EN
    input  logic                        stat_clear,
    output logic [0:NUM_CHANNELS-1][15:0] stat_pkt_count,
`endif
    noc_axis_inject_arbiter_if.slave    bus
);

    localparam int GRANT_W  = $clog2(NUM_CHANNELS);
    localparam int CREDIT_W = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(FLIT_BUFFER_DEPTH);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [GRANT_W-1:0]      r_grant;
    logic [GRANT_W-1:0]      w_grant_nxt;
    logic [GRANT_W-1:0]      r_last_grant;
    logic [GRANT_W-1:0]      w_last_grant_nxt;
    logic [CREDIT_W-1:0]     r_credits;

    logic                    w_arb_found;
    logic [GRANT_W-1:0]      w_arb_grant;
    logic [GRANT_W-1:0]      w_scan_idx;
    logic [0:NUM_CHANNELS-1] w_tready;
    logic                    w_hs;
    logic                    w_pkt_done;
    logic                    w_credit_add;

    logic                    r_send_p1;
    logic [TDATA_WIDTH-1:0]  r_data_p1;
    logic [DEST_WIDTH-1:0]   r_dest_p1;
    logic                    r_tail_p1;

    // Round-robin search: first valid channel starting one above the last
    // packet's winner, wrapping around; the last winner is checked last.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_grant = r_last_grant;
        w_scan_idx  = r_last_grant;
        for (int i = 1; i <= NUM_CHANNELS; i++) begin
            w_scan_idx = GRANT_W'((int'(r_last_grant) + i) % NUM_CHANNELS);
            if (!w_arb_found && bus.axis_in_tvalid[w_scan_idx]) begin
                w_arb_found = 1'b1;
                w_arb_grant = w_scan_idx;
            end
        end
    end

    // Next-state and ready logic. Ready is only ever offered to the locked
    // channel, and only while a downstream buffer slot is known to be free.
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_tready         = '0;
        w_hs             = 1'b0;
        w_pkt_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_found) begin
                    w_state_nxt = ST_LOCKED;
                    w_grant_nxt = w_arb_grant;
                end
            end
            ST_LOCKED: begin
                w_tready[r_grant] = (r_credits != '0);
                w_hs              = bus.axis_in_tvalid[r_grant] && w_tready[r_grant];
                w_pkt_done        = w_hs && bus.axis_in_tlast[r_grant];
                if (w_pkt_done) begin
                    w_state_nxt      = ST_IDLE;
                    w_last_grant_nxt = r_grant;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.axis_in_tready = w_tready;

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= GRANT_W'(NUM_CHANNELS - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // A credit returned while the counter is already full has no slot to
    // account for; it is dropped rather than wrapping the counter.
    assign w_credit_add = bus.credit_in && (r_credits != CREDIT_MAX);

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            r_credits <= CREDIT_MAX;
        end else if (w_hs && !w_credit_add) begin
            r_credits <= r_credits - CREDIT_W'(1);
        end else if (!w_hs && w_credit_add) begin
            r_credits <= r_credits + CREDIT_W'(1);
        end
    end

    a_credit_overflow: assert property (
        @(posedge clk_noc) disable iff (rst_noc)
        !(bus.credit_in && (r_credits == CREDIT_MAX))
    );

    // ---- stage p0 -> p1: register the accepted flit towards the router ----
    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            r_send_p1 <= 1'b0;
            r_data_p1 <= '0;
            r_dest_p1 <= '0;
            r_tail_p1 <= 1'b0;
        end else begin
            r_send_p1 <= w_hs;
            if (w_hs) begin
                r_data_p1 <= bus.axis_in_tdata[r_grant];
                r_dest_p1 <= {TID_WIDTH'(r_grant), bus.axis_in_tdest[r_grant]};
                r_tail_p1 <= bus.axis_in_tlast[r_grant];
            end
        end
    end

    assign bus.send_out    = r_send_p1;
    assign bus.data_out    = r_data_p1;
    assign bus.dest_out    = r_dest_p1;
    assign bus.is_tail_out = r_tail_p1;

`ifdef NOC_INJECT_STATS_EN
    logic [0:NUM_CHANNELS-1][15:0] r_stat_cnt;

    // Clear wins over a same-cycle packet completion.
    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            r_stat_cnt <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (stat_clear) begin
                    r_stat_cnt[c] <= '0;
                end else if (w_pkt_done && (r_grant == GRANT_W'(c)) &&
                             (r_stat_cnt[c] != 16'hFFFF)) begin
                    r_stat_cnt[c] <= r_stat_cnt[c] + 16'd1;
                end
            end
        end
    end

    assign stat_pkt_count = r_stat_cnt;
`endif

endmodule

// File: tb/tb_noc_axis_inject_arbiter.sv
// ---------------------------------------------------------------------------
// tb_noc_axis_inject_arbiter
// Directed bench for noc_axis_inject_arbiter: a per-cycle vector table for
// single-channel packets and credit starvation, plus hand-written sequences
// for four-way round robin, reset mid-packet and (with NOC_INJECT_STATS_EN)
// the packet counters.
// ---------------------------------------------------------------------------
module tb_noc_axis_inject_arbiter;

    localparam int NCH = 4;

    logic clk_noc = 1'b0;
    logic rst_noc;

    noc_axis_inject_arbiter_if #(
        .NUM_CHANNELS(NCH), .TDATA_WIDTH(64), .TDEST_WIDTH(4), .TID_WIDTH(2)
    ) bus ();

`ifdef NOC_INJECT_STATS_EN
    logic                   stat_clear;
    logic [0:NCH-1][15:0]   stat_pkt_count;
`endif

    noc_axis_inject_arbiter #(
        .NUM_CHANNELS(NCH), .TDATA_WIDTH(64), .TDEST_WIDTH(4), .TID_WIDTH(2),
        .FLIT_BUFFER_DEPTH(4)
    ) dut (
        .clk_noc        (clk_noc),
        .rst_noc        (rst_noc),
`ifdef NOC_INJECT_STATS_EN
        .stat_clear     (stat_clear),
        .stat_pkt_count (stat_pkt_count),
`endif
        .bus            (bus)
    );

    always #5 clk_noc = ~clk_noc;

    // One record = inputs held for one clock cycle, and the outputs expected
    // just after the edge that closes that cycle.
    typedef struct packed {
        logic       rst;
        logic [0:3] vld;
        logic [0:3] last;
        logic [3:0] flit;
        logic [3:0] dest;
        logic       cred;
        logic [0:3] e_rdy;
        logic       e_send;
        logic [7:0] e_data;
        logic [5:0] e_dest;
        logic       e_tail;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_noc);
        #1;
    endtask

    task automatic idle_inputs();
        bus.axis_in_tvalid = '0;
        bus.axis_in_tlast  = '0;
        bus.axis_in_tdata  = '0;
        bus.axis_in_tdest  = '0;
        bus.credit_in      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_noc = 1'b1;
        tick();
        rst_noc = 1'b0;
    endtask

    // Channel c presents data c*16 + flit number, so data identifies both.
    task automatic apply(input vec_t v, input int idx);
        rst_noc       = v.rst;
        bus.credit_in = v.cred;
        for (int c = 0; c < NCH; c++) begin
            bus.axis_in_tvalid[c] = v.vld[c];
            bus.axis_in_tlast[c]  = v.last[c];
            bus.axis_in_tdata[c]  = 64'(c * 16 + int'(v.flit));
            bus.axis_in_tdest[c]  = v.dest;
        end
        tick();
        check($sformatf("v%0d_tready", idx), 64'(bus.axis_in_tready), 64'(v.e_rdy));
        check($sformatf("v%0d_send", idx), 64'(bus.send_out), 64'(v.e_send));
        if (v.e_send || v.rst) begin
            check($sformatf("v%0d_data", idx), bus.data_out, 64'(v.e_data));
            check($sformatf("v%0d_dest", idx), 64'(bus.dest_out), 64'(v.e_dest));
            check($sformatf("v%0d_tail", idx), 64'(bus.is_tail_out), 64'(v.e_tail));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          cnt [NCH];
        logic [0:3]  rdy;
        logic        prev_send;
        int          p, ch, fl;
        logic        exp_send;

`ifdef NOC_INJECT_STATS_EN
        stat_clear = 1'b0;
`endif
        idle_inputs();
        rst_noc = 1'b1;

        //                 rst  vld      last     flt  dst  crd  e_rdy    snd  data   dest   tail
        // reset
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 4'd0, 4'h0, 1'b0, 4'b0000, 1'b0, 8'h00, 6'h00, 1'b0});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 4'd0, 4'h0, 1'b0, 4'b0000, 1'b0, 8'h00, 6'h00, 1'b0});
        // ch2, 3-flit packet, tdest 5, credits looped back
        tbl.push_back('{1'b0, 4'b0010, 4'b0000, 4'd1, 4'h5, 1'b0, 4'b0010, 1'b0, 8'h00, 6'h00, 1'b0});
        tbl.push_back('{1'b0, 4'b0010, 4'b0000, 4'd1, 4'h5, 1'b0, 4'b0010, 1'b1, 8'h21, 6'h25, 1'b0});
        tbl.push_back('{1'b0, 4'b0010, 4'b0000, 4'd2, 4'h5, 1'b0, 4'b0010, 1'b1, 8'h22, 6'h25, 1'b0});
        tbl.push_back('{1'b0, 4'b0010, 4'b0010, 4'd3, 4'h5, 1'b1, 4'b0000, 1'b1, 8'h23, 6'h25, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 4'd0, 4'h5, 1'b1, 4'b0000, 1'b0, 8'h00, 6'h00, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 4'd0, 4'h5, 1'b1, 4'b0000, 1'b0, 8'h00, 6'h00, 1'b0});
        // ch0, 6-flit packet, no credits returned until starvation
        tbl.push_back('{1'b0, 4'b1000, 4'b0000, 4'd1, 4'h3, 1'b0, 4'b1000, 1'b0, 8'h00, 6'h00, 1'b0});
        tbl.push_back('{1'b0, 4'b1000, 4'b0000, 4'd1, 4'h3, 1'b0, 4'b1000, 1'b1, 8'h01, 6'h03, 1'b0});
        tbl.push_back('{1'b0, 4'b1000, 4'b0000, 4'd2, 4'h3, 1'b0, 4'b1000, 1'b1, 8'h02, 6'h03, 1'b0});
        tbl.push_back('{1'b0, 4'b1000, 4'b0000, 4'd3, 4'h3, 1'b0, 4'b1000, 1'b1, 8'h03, 6'h03, 1'b0});
        tbl.push_back('{1'b0, 4'b1000, 4'b0000, 4'd4, 4'h3, 1'b0, 4'b0000, 1'b1, 8'h04, 6'h03, 1'b0});
        tbl.push_back('{1'b0, 4'b1000, 4'b0000, 4'd5, 4'h3, 1'b0, 4'b0000, 1'b0, 8'h00, 6'h00, 1'b0});
        tbl.push_back('{1'b0, 4'b1000, 4'b0000, 4'd5, 4'h3, 1'b1, 4'b1000, 1'b0, 8'h00, 6'h00, 1'b0});
        tbl.push_back('{1'b0, 4'b1000, 4'b0000, 4'd5, 4'h3, 1'b0, 4'b0000, 1'b1, 8'h05, 6'h03, 1'b0});
        tbl.push_back('{1'b0, 4'b1000, 4'b1000, 4'd6, 4'h3, 1'b1, 4'b1000, 1'b0, 8'h00, 6'h00, 1'b0});
        tbl.push_back('{1'b0, 4'b1000, 4'b1000, 4'd6, 4'h3, 1'b1, 4'b0000, 1'b1, 8'h06, 6'h03, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 4'd0, 4'h3, 1'b1, 4'b0000, 1'b0, 8'h00, 6'h00, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 4'd0, 4'h3, 1'b1, 4'b0000, 1'b0, 8'h00, 6'h00, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 4'd0, 4'h3, 1'b1, 4'b0000, 1'b0, 8'h00, 6'h00, 1'b0});

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // ---- all four channels with 2-flit packets, credits looped back ----
        do_reset();
        for (int c = 0; c < NCH; c++) cnt[c] = 0;
        prev_send = 1'b0;
        bus.axis_in_tvalid = '1;
        for (int i = 0; i < 15; i++) begin
            for (int c = 0; c < NCH; c++) begin
                bus.axis_in_tdata[c] = 64'(c * 16 + cnt[c] + 1);
                bus.axis_in_tlast[c] = (cnt[c] == 1);
                bus.axis_in_tdest[c] = 4'h9;
            end
            bus.credit_in = prev_send;
            rdy = bus.axis_in_tready;
            tick();
            for (int c = 0; c < NCH; c++) begin
                if (rdy[c]) cnt[c] = 1 - cnt[c];
            end
            prev_send = bus.send_out;
            p  = i / 3;
            ch = p % NCH;
            fl = i % 3;
            exp_send = (fl != 0);
            check($sformatf("rr%0d_send", i), 64'(bus.send_out), 64'(exp_send));
            if (exp_send) begin
                check($sformatf("rr%0d_data", i), bus.data_out, 64'(ch * 16 + fl));
                check($sformatf("rr%0d_dest", i), 64'(bus.dest_out), 64'(ch * 16 + 9));
                check($sformatf("rr%0d_tail", i), 64'(bus.is_tail_out), 64'(fl == 2));
            end
        end
        bus.axis_in_tvalid = '0;
        bus.credit_in = prev_send;
        tick();
        bus.credit_in = 1'b0;
        tick();

        // ---- reset in the middle of a 4-flit packet on ch1 ----
        do_reset();
        bus.axis_in_tvalid = 4'b0100;
        bus.axis_in_tdest[1] = 4'h7;
        bus.axis_in_tdata[1] = 64'h11;
        tick();
        check("mr_grant1", 64'(bus.axis_in_tready), 64'(4'b0100));
        tick();
        check("mr_flit1", bus.data_out, 64'h11);
        bus.axis_in_tdata[1] = 64'h12;
        tick();
        check("mr_flit2", bus.data_out, 64'h12);
        rst_noc = 1'b1;
        #1;
        check("mr_rst_send", 64'(bus.send_out), 64'd0);
        check("mr_rst_data", bus.data_out, 64'd0);
        check("mr_rst_dest", 64'(bus.dest_out), 64'd0);
        check("mr_rst_tail", 64'(bus.is_tail_out), 64'd0);
        check("mr_rst_tready", 64'(bus.axis_in_tready), 64'd0);
        check("mr_rst_credits", 64'(dut.r_credits), 64'd4);
        @(posedge clk_noc);
        #1;
        rst_noc = 1'b0;
        bus.axis_in_tvalid = 4'b1100;
        bus.axis_in_tdata[0] = 64'h01;
        bus.axis_in_tdest[0] = 4'h7;
        tick();
        check("mr_regrant", 64'(bus.axis_in_tready), 64'(4'b1000));
        tick();
        check("mr_ch0_send", 64'(bus.send_out), 64'd1);
        check("mr_ch0_dest", 64'(bus.dest_out), 64'h07);

`ifdef NOC_INJECT_STATS_EN
        // ---- packet counters: three single-flit packets on ch3, then a
        //      fourth whose completion coincides with stat_clear ----
        do_reset();
        bus.axis_in_tvalid   = 4'b0001;
        bus.axis_in_tlast    = 4'b0001;
        bus.axis_in_tdata[3] = 64'h31;
        for (int i = 0; i < 4; i++) begin
            bus.credit_in = (i > 0);
            stat_clear = 1'b0;
            tick();
            bus.credit_in = 1'b0;
            stat_clear = (i == 3);
            tick();
            if (i == 2) check("stat_ch3_three", 64'(stat_pkt_count[3]), 64'd3);
        end
        stat_clear = 1'b0;
        bus.axis_in_tvalid = '0;
        bus.credit_in = 1'b1;
        tick();
        bus.credit_in = 1'b0;
        check("stat_ch3_cleared", 64'(stat_pkt_count[3]), 64'd0);
        check("stat_ch0_zero", 64'(stat_pkt_count[0]), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
